// File: rtl/bias_accumulate_unit.sv
// Bias-add / saturate / optional ReLU stage behind the adder tree.
// Accumulates multi-beat partial sums per lane and holds one result until the consumer takes it.

module bias_accumulate_unit_lane #(
  parameter int DW   = 18,
  parameter int ACCW = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 beat,
  input  logic                 first,
  input  logic                 last,
  input  logic                 relu,
  input  logic signed [DW-1:0] in_lane,
  input  logic signed [DW-1:0] bias_lane,
  output logic        [DW-1:0] out_lane
);
  localparam logic signed [ACCW:0] SMAX = {{(ACCW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW:0] SMIN = {{(ACCW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACCW-1:0] acc, base, tot;
  logic signed [ACCW:0]   sum;
  logic        [DW-1:0]   sat, res;

  always_comb begin
    base = first ? '0 : acc;
    tot  = base + {{(ACCW-DW){in_lane[DW-1]}}, in_lane};
    // one extra bit so the bias add can never wrap before the clamp
    sum  = {tot[ACCW-1], tot} + {{(ACCW-DW+1){bias_lane[DW-1]}}, bias_lane};
    if (sum > SMAX)      sat = SMAX[DW-1:0];
    else if (sum < SMIN) sat = SMIN[DW-1:0];
    else                 sat = sum[DW-1:0];
    res = (relu && sat[DW-1]) ? '0 : sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      out_lane <= '0;
    end else if (beat) begin
      acc <= tot;
      if (last) out_lane <= res;
    end
  end
endmodule

module bias_accumulate_unit #(
  parameter int N_adder_tree = 16,
  parameter int DW           = 18,
  parameter int MAX_BEATS    = 64,
  parameter int ACCW         = DW + $clog2(MAX_BEATS) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_adder_tree*DW-1:0] in_data,
  input  logic                       in_last,
  input  logic [N_adder_tree*DW-1:0] bias,
  input  logic                       relu_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_adder_tree*DW-1:0] out_data,
  output logic                       err_overflow
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {ACC, HOLD} state_t;

  state_t         state;
  logic           first;
  logic [CW-1:0]  cnt;
  logic           beat;

  logic [N_adder_tree-1:0][DW-1:0] in_v, bias_v, out_v;

  assign in_v     = in_data;
  assign bias_v   = bias;
  assign out_data = out_v;
  assign beat     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACC;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      first        <= 1'b1;
      cnt          <= '0;
      err_overflow <= 1'b0;
    end else begin
      case (state)
        ACC: if (beat) begin
          if (cnt == CW'(MAX_BEATS) && !in_last) err_overflow <= 1'b1;
          if (in_last) begin
            state     <= HOLD;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            first     <= 1'b1;
            cnt       <= '0;
          end else begin
            first <= 1'b0;
            // counter pins at the limit; later beats keep flagging overflow
            if (cnt != CW'(MAX_BEATS)) cnt <= cnt + 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          state     <= ACC;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
        default: state <= ACC;
      endcase
    end
  end

  for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
    bias_accumulate_unit_lane #(.DW(DW), .ACCW(ACCW)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .beat     (beat),
      .first    (first),
      .last     (in_last),
      .relu     (relu_en),
      .in_lane  (in_v[g]),
      .bias_lane(bias_v[g]),
      .out_lane (out_v[g])
    );
  end
endmodule

// File: doc/bias_accumulate_unit.md
BIAS_ACCUMULATE_UNIT -- requirements
Module: bias_accumulate_unit

Interface
REQ-001 Parameter N_adder_tree, default 16: number of parallel output lanes.
REQ-002 Parameter DW, default 18: lane width in bits; two's complement, same Q format as bias words.
REQ-003 Parameter MAX_BEATS, default 64: maximum accepted beats per accumulation group.
REQ-004 Parameter ACCW, default DW+$clog2(MAX_BEATS)+1: internal accumulator width in bits.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  partial-sum beat present.
REQ-008 in_ready  output  1  unit accepts a beat this cycle.
REQ-009 in_data  input  N_adder_tree*DW  adder-tree partial sums; lane i at bits [DW*(i+1)-1:DW*i].
REQ-010 in_last  input  1  final beat of the current group; qualified by in_valid.
REQ-011 bias  input  N_adder_tree*DW  per-lane bias words, static during a group; lane packing as in_data.
REQ-012 relu_en  input  1  clamp negative results to zero; sampled on the last-beat handshake.
REQ-013 out_valid  output  1  out_data holds a finished result.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_data  output  N_adder_tree*DW  biased, saturated and optionally ReLU'd results; lane packing as in_data.
REQ-016 err_overflow  output  1  sticky flag: beat count exceeded MAX_BEATS.

Function
REQ-017 The unit SHALL have two states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-018 A beat SHALL be accepted only when in_valid and in_ready are both 1 in the same cycle.
REQ-019 The first beat accepted in a group SHALL load each lane accumulator with the sign-extended in_data lane; each later beat SHALL add its lane to the accumulator.
REQ-020 Accumulation SHALL use ACCW-bit signed arithmetic with no intermediate saturation.
REQ-021 On acceptance of a beat with in_last=1, the unit SHALL enter HOLD on the next edge.
REQ-022 On that same edge, out_data lane i SHALL be registered as sat(acc_i + in_i + sign-extended bias_i), where acc_i is the accumulator value before this beat (0 for a one-beat group).
REQ-023 sat() SHALL clamp to the range [-2^(DW-1), 2^(DW-1)-1]; for DW=18 this is [-131072, 131071].
REQ-024 When relu_en was 1 at the last-beat handshake, a negative saturated result SHALL be output as 0.
REQ-025 Latency from the last-beat handshake to out_valid=1 SHALL be exactly 1 cycle.
REQ-026 In HOLD, out_data and out_valid SHALL remain stable until out_ready=1.
REQ-027 In HOLD with out_ready=1, the unit SHALL return to ACC on the next edge and mark the next beat as first of a new group.
REQ-028 in_ready SHALL be 0 in HOLD, including the cycle in which out_ready=1; there is no input/output overlap.
REQ-029 A beat counter SHALL count accepted beats per group.
REQ-030 When a beat is accepted with the count already at MAX_BEATS and in_last=0, err_overflow SHALL be set to 1; accumulation continues, with wrap permitted.
REQ-031 err_overflow SHALL clear only on rst.
REQ-032 in_valid=0 in ACC SHALL leave all state unchanged; bubbles between beats are legal.

Reset
REQ-033 While rst=1, state SHALL be ACC and out_valid SHALL be 0.
REQ-034 While rst=1, out_data SHALL be 0, all accumulators SHALL be 0, the beat counter SHALL be 0, err_overflow SHALL be 0, and the first-beat flag SHALL be set.
REQ-035 rst asserted mid-group or in HOLD SHALL discard all partial and pending results; in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-036 Single beat, lane0 in=100, bias=3958, relu_en=0, out_ready=1 -> out_valid one cycle later, lane0=4058.
REQ-037 Three beats lane0 = 1000, -2000, 500 with bias=-5 -> lane0 = -505 with relu_en=0, and 0 with relu_en=1.
REQ-038 Four beats lane0=+100000 each, bias=0 -> lane0 saturates to 131071; the same test with -100000 -> -131072.
REQ-039 Hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0; then out_ready=1 -> in_ready=1 on the next cycle and the next group starts fresh.
REQ-040 MAX_BEATS+1 beats without in_last -> err_overflow=1 and stays 1 through the following groups until rst.
REQ-041 Assert rst after 2 of 3 beats, then run a 1-beat group with in=7, bias=0 -> output 7, with no residue from the aborted group.
